// File: rtl/cmp_result_collector.sv
// Collects single-bit domino comparator results into batches of BATCH bits.
// Each batch carries its length and hit count and is handed off over valid/ready.
module cmp_result_collector #(
    parameter int BATCH = 8,
    localparam int CW = $clog2(BATCH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_out,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BATCH-1:0] batch_bits,
    output logic [CW-1:0]    batch_len,
    output logic [CW-1:0]    hit_count,
    output logic             dropped
);

    localparam logic S_COLLECT = 1'b0;
    localparam logic S_HOLD    = 1'b1;

    logic state;

    // batch_len doubles as the write index for the next accepted result.
    logic [BATCH-1:0] result_bit;
    logic [CW-1:0]    hit_inc;
    logic             last_slot;
    logic             close_early;

    assign in_ready    = (state == S_COLLECT);
    assign out_valid   = (state == S_HOLD);
    assign result_bit  = {{(BATCH-1){1'b0}}, cmp_out} << batch_len;
    assign hit_inc     = {{(CW-1){1'b0}}, cmp_out};
    assign last_slot   = (batch_len == CW'(BATCH - 1));
    assign close_early = flush && ((batch_len != '0) || in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_COLLECT;
            batch_bits <= '0;
            batch_len  <= '0;
            hit_count  <= '0;
            dropped    <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (in_valid) begin
                        batch_bits <= batch_bits | result_bit;
                        batch_len  <= batch_len + CW'(1);
                        hit_count  <= hit_count + hit_inc;
                    end
                    if ((in_valid && last_slot) || close_early) begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        // A result offered during the handshake belongs to the next batch's drop report.
                        state      <= S_COLLECT;
                        batch_bits <= '0;
                        batch_len  <= '0;
                        hit_count  <= '0;
                        dropped    <= in_valid;
                    end else if (in_valid) begin
                        dropped <= 1'b1;
                    end
                end
                default: state <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_result_collector.sv
// Directed testbench for cmp_result_collector with hand-computed expectations.
module tb_cmp_result_collector;

    localparam int BATCH = 8;
    localparam int CW = $clog2(BATCH + 1);

    logic             clk;
    logic             rst;
    logic             cmp_out;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [BATCH-1:0] batch_bits;
    logic [CW-1:0]    batch_len;
    logic [CW-1:0]    hit_count;
    logic             dropped;

    int errors = 0;
    int checks = 0;
    int valid_cycles;

    cmp_result_collector #(.BATCH(BATCH)) dut (
        .clk(clk),
        .rst(rst),
        .cmp_out(cmp_out),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .batch_bits(batch_bits),
        .batch_len(batch_len),
        .hit_count(hit_count),
        .dropped(dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge take them, then settle 1 time unit past it.
    task automatic applyStimulus(input logic v, input logic c, input logic f, input logic r);
        in_valid  = v;
        cmp_out   = c;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkBatch(input string tag, input logic ov, input logic [7:0] bits,
                              input int len, input int hits, input logic drp);
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        checkOutput({tag, ".bits"}, 32'(batch_bits), 32'(bits));
        checkOutput({tag, ".len"}, 32'(batch_len), 32'(len));
        checkOutput({tag, ".hits"}, 32'(hit_count), 32'(hits));
        checkOutput({tag, ".dropped"}, 32'(dropped), 32'(drp));
    endtask

    initial begin
        logic [7:0] stream1;
        stream1 = 8'b10101001;
        rst = 1'b1;
        in_valid = 1'b0;
        cmp_out = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        #12;
        checkBatch("reset", 1'b0, 8'h00, 0, 0, 1'b0);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Full batch of eight results, no back-pressure release.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, stream1[i], 1'b0, 1'b0);
            if (i == 6) checkOutput("t1.pre_valid", 32'(out_valid), 32'd0);
        end
        checkBatch("t1", 1'b1, 8'b10101001, 8, 4, 1'b0);
        checkOutput("t1.in_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkBatch("t2.held", 1'b1, 8'b10101001, 8, 4, 1'b1);
        checkOutput("t2.in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkBatch("t2.cleared", 1'b0, 8'h00, 0, 0, 1'b0);
        checkOutput("t2.in_ready", 32'(in_ready), 32'd1);

        // Partial batch closed by a standalone flush.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t3.pre_flush", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkBatch("t3", 1'b1, 8'b00000011, 3, 2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkBatch("t3.flush_in_hold", 1'b1, 8'b00000011, 3, 2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        // Flush together with the first accept, then an empty flush.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkBatch("t4.same_cycle", 1'b1, 8'b00000001, 1, 1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkBatch("t4.empty_flush", 1'b0, 8'h00, 0, 0, 1'b0);
        checkOutput("t4.in_ready", 32'(in_ready), 32'd1);

        // Continuous stream with out_ready held high: each handshake cycle loses one result.
        valid_cycles = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
            if (out_valid) valid_cycles++;
            if (i == 7)  checkBatch("t5.batch1", 1'b1, 8'hFF, 8, 8, 1'b0);
            if (i == 8)  checkBatch("t5.after1", 1'b0, 8'h00, 0, 0, 1'b1);
            if (i == 16) checkBatch("t5.batch2", 1'b1, 8'hFF, 8, 8, 1'b1);
            if (i == 17) checkOutput("t5.after2", 32'(out_valid), 32'd0);
        end
        checkOutput("t5.valid_cycles", 32'(valid_cycles), 32'd2);

        // Asynchronous reset mid-batch.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6.mid_len", 32'(batch_len), 32'd5);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 checkBatch("t6.async_mid", 1'b0, 8'h00, 0, 0, 1'b0);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t6.hold", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 checkBatch("t6.async_hold", 1'b0, 8'h00, 0, 0, 1'b0);
        checkOutput("t6.in_ready", 32'(in_ready), 32'd1);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6.first_bit", 32'(batch_bits), 32'h01);
        checkOutput("t6.first_len", 32'(batch_len), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
